vc_mem_responder: RTL

//  Memory-side responder for the victim-cache write-back port (mem_req/mem_req_write/mem_req_tag/mem_req_wdata -> mem_resp_valid).

---
 rtl/vc_pkg.sv | 20 ++
 rtl/vc_mem_array.sv | 51 +++++
 rtl/vc_mem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Purpose: shared types and defaults for the victim-cache memory responder.
//   mem_state_t       : responder FSM states (idle, latency wait, response).
//   VC_*_LATENCY_DEF  : default write/read latencies in cycles.
//   vc_max            : helper to size the latency counter.
package vc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } mem_state_t;

    localparam int unsigned VC_WR_LATENCY_DEF = 4;
    localparam int unsigned VC_RD_LATENCY_DEF = 6;

    function automatic int unsigned vc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vc_mem_array.sv
// Purpose: tagged line store for the memory responder, MEM_LINES entries of
//   {valid, tag, data}. Synchronous clear on rst, one write port, combinational
//   read on the same index. Holds no control state.
// Ports:
//   clk, rst   : clock, synchronous active-high clear of every entry
//   we         : write enable; entry[idx] <= {1, wtag, wdata}
//   idx        : entry index for both read and write
//   wtag/wdata : write tag and line
//   rd_valid/rd_tag/rd_data : contents of entry[idx]
module vc_mem_array #(
    parameter int unsigned TAG_WIDTH = 20,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MEM_LINES = 64,
    parameter int unsigned IDX_W     = $clog2(MEM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [TAG_WIDTH-1:0] wtag,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 rd_valid,
    output logic [TAG_WIDTH-1:0] rd_tag,
    output logic [DATA_W-1:0]    rd_data
);

    logic                 valid_q [MEM_LINES];
    logic [TAG_WIDTH-1:0] tag_q   [MEM_LINES];
    logic [DATA_W-1:0]    data_q  [MEM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (we) begin
            valid_q[idx] <= 1'b1;
            tag_q[idx]   <= wtag;
            data_q[idx]  <= wdata;
        end
    end

    always_comb begin
        rd_valid = valid_q[idx];
        rd_tag   = tag_q[idx];
        rd_data  = data_q[idx];
    end

endmodule

// File: rtl/vc_mem_responder.sv
// Purpose: backing-memory endpoint for the victim-cache write-back port.
//   Accepts one line request at a time, waits a fixed write/read latency,
//   commits writes into a tagged line store and answers reads with hit/miss.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem_req         : request valid, held by requester until mem_resp_valid
//   mem_req_write   : 1 = write-back, 0 = line read
//   mem_req_tag     : line address (low IDX_W bits select the store entry)
//   mem_req_wdata   : write line
//   mem_resp_valid  : one-cycle completion pulse
//   mem_resp_rdata  : read line on read responses, otherwise 0
//   mem_resp_miss   : read to absent/aliased line, with mem_resp_valid
//   busy            : transaction in progress (S_BUSY or S_RESP)
//   err_abort       : sticky, mem_req dropped before completion
//   wb_count/rd_count : saturating completed-write / completed-read counts
module vc_mem_responder
    import vc_pkg::*;
#(
    parameter int unsigned TAG_WIDTH  = 20,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned MEM_LINES  = 64,
    parameter int unsigned WR_LATENCY = VC_WR_LATENCY_DEF,
    parameter int unsigned RD_LATENCY = VC_RD_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    mem_req_write,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic [LINE_BYTES*8-1:0] mem_req_wdata,
    output logic                    mem_resp_valid,
    output logic [LINE_BYTES*8-1:0] mem_resp_rdata,
    output logic                    mem_resp_miss,
    output logic                    busy,
    output logic                    err_abort,
    output logic [15:0]             wb_count,
    output logic [15:0]             rd_count
);

    localparam int unsigned DATA_W = LINE_BYTES * 8;
    localparam int unsigned IDX_W  = $clog2(MEM_LINES);
    localparam int unsigned CNT_W  = $clog2(vc_max(WR_LATENCY, RD_LATENCY) + 1);

    mem_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic                 write_r;
    logic [TAG_WIDTH-1:0] tag_r;
    logic [DATA_W-1:0]    wdata_r;

    logic capture, abort, finish;

    logic                 st_valid;
    logic [TAG_WIDTH-1:0] st_tag;
    logic [DATA_W-1:0]    st_data;
    logic                 hit;

    vc_mem_array #(
        .TAG_WIDTH (TAG_WIDTH),
        .DATA_W    (DATA_W),
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .we       (finish && write_r),
        .idx      (tag_r[IDX_W-1:0]),
        .wtag     (tag_r),
        .wdata    (wdata_r),
        .rd_valid (st_valid),
        .rd_tag   (st_tag),
        .rd_data  (st_data)
    );

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        capture        = 1'b0;
        abort          = 1'b0;
        finish         = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_miss  = 1'b0;
        busy           = (state != S_IDLE);
        hit            = st_valid && (st_tag == tag_r);

        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    capture    = 1'b1;
                    cnt_next   = mem_req_write ? CNT_W'(WR_LATENCY - 1)
                                               : CNT_W'(RD_LATENCY - 1);
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // A dropped request wins over the latency expiring.
                if (!mem_req) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_RESP: begin
                finish         = 1'b1;
                mem_resp_valid = 1'b1;
                if (!write_r) begin
                    mem_resp_rdata = hit ? st_data : '0;
                    mem_resp_miss  = !hit;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            write_r   <= 1'b0;
            tag_r     <= '0;
            wdata_r   <= '0;
            err_abort <= 1'b0;
            wb_count  <= '0;
            rd_count  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                write_r <= mem_req_write;
                tag_r   <= mem_req_tag;
                wdata_r <= mem_req_wdata;
            end
            if (abort) begin
                err_abort <= 1'b1;
            end
            if (finish) begin
                if (write_r) begin
                    if (wb_count != '1) wb_count <= wb_count + 16'd1;
                end else begin
                    if (rd_count != '1) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

endmodule
